// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier / product-accumulator datapath.
// Holds the accumulator FSM state encoding and the default widths shared with
// the unsigned multiplier (PROD_W matches its 64-bit z output).
package mul_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mul_acc_adder.sv
// Combinational ACC_W-bit adder for the product accumulator.
// Returns the sum and the carry out of bit ACC_W-1.
// Build option MUL_ACC_SATURATE_EN: when defined, a carry forces the sum to
// all-ones instead of the wrapped value. Once the running sum is all-ones,
// any further nonzero addend carries again, so saturation persists for the
// rest of the burst without extra state.
module mul_acc_adder #(
  parameter int ACC_W = mul_pkg::ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full_sum;

  // Full-width add with one extra bit to capture the carry.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
    carry    = full_sum[ACC_W];
`ifdef MUL_ACC_SATURATE_EN
    sum      = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    sum      = full_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mul_prod_accumulator.sv
// Product accumulator: sums a burst of len unsigned products into a wide
// register and presents the total on a valid/ready output handshake.
// Build option MUL_ACC_SATURATE_EN selects saturating (vs. wrapping)
// accumulation inside mul_acc_adder; handshake timing is the same either way.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; acc/overflow keep the last burst result
// ST_ACCUM | prod_ready high, one product added per prod_valid cycle
// ST_DONE  | acc_valid high, acc/overflow frozen until acc_ready
module mul_prod_accumulator
  import mul_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow,
  output logic              busy
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             xfer;

  mul_acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .a     (acc_q),
    .b     (ACC_W'(prod)),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Handshake outputs are pure decodes of the registered state.
  always_comb begin
    prod_ready = (state_q == ST_ACCUM);
    acc_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    acc        = acc_q;
    overflow   = overflow_q;
    xfer       = prod_valid & prod_ready;
  end

  // Next-state and datapath update for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d    = len;
          acc_d      = '0;
          overflow_d = 1'b0;
          state_d    = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          acc_d      = add_sum;
          overflow_d = overflow_q | add_carry;
          count_d    = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here; it is taken next cycle in IDLE.
        if (acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
